fb_write_arbiter: RTL and testbench

//   Shares the single QQVGA framebuffer write port (we/write_addr/pixel) between N_REQ

---
 rtl/fb_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/fb_write_arbiter.sv | 124 ++++++++++++
 tb/tb_fb_write_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Framebuffer geometry and write-arbiter state type shared by filler, arbiter and VGA read side.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package fb_pkg;

  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;
  localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;

  typedef enum logic {ARB, CLEAR} fb_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: first asserted request at or above ptr, wrapping at N_REQ.
// Latency: purely combinational.
// Backpressure: none; caller decides whether the grant is used.
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant
);

  // Scan from farthest to nearest offset so the nearest valid requester overwrites the rest
  always_comb begin
    grant = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      logic [PTR_W:0] pos;
      pos = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (pos >= (PTR_W + 1)'(N_REQ)) begin
        pos = pos - (PTR_W + 1)'(N_REQ);
      end
      if (req[pos[PTR_W-1:0]]) begin
        grant = '0;
        grant[pos[PTR_W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin share of the framebuffer write port among N_REQ writers, plus a full-frame clear sequencer.
// Latency: accepted request appears on we/write_addr/pixel one cycle later; one write per cycle.
// Backpressure: req_ready is a one-hot grant, all-zero while clearing; FB_BOUNDS_CHECK_EN drops out-of-range writes.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int   ADDR_WIDTH  = 15,
  parameter int   N_REQ       = 3,
  parameter logic CLEAR_PIXEL = 1'b0
) (
  input  logic                        clk_25,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ-1:0]            req_pixel,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        clear_start,
  output logic                        clear_busy,
  output logic                        clear_done,
  output logic                        oob_err,
  output logic                        we,
  output logic [ADDR_WIDTH-1:0]       write_addr,
  output logic                        pixel
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_DEPTH - 1);
  localparam logic [PTR_W-1:0]      LAST_REQ  = PTR_W'(N_REQ - 1);

  fb_arb_state_t           state;
  logic [PTR_W-1:0]        rr_ptr;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [N_REQ-1:0]        grant;
  logic [PTR_W-1:0]        sel_idx;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic                    sel_pixel;
  logic                    sel_oob;
  logic                    transfer;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // A clear request wins over any pending writer in the cycle it arrives
  assign req_ready = (state == ARB && !clear_start) ? grant : '0;
  assign transfer  = |req_ready;

  // Encode the one-hot grant into the winner's index, address and pixel
  always_comb begin
    sel_idx   = '0;
    sel_addr  = '0;
    sel_pixel = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        sel_idx   = PTR_W'(k);
        sel_addr  = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_pixel = req_pixel[k];
      end
    end
  end

`ifdef FB_BOUNDS_CHECK_EN
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(FB_DEPTH);
  assign sel_oob = ({1'b0, sel_addr} >= DEPTH_EXT);
`else
  assign sel_oob = 1'b0;
`endif

  // Arbitration/clear FSM with registered write port and status outputs
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARB;
      rr_ptr     <= '0;
      clr_cnt    <= '0;
      we         <= 1'b0;
      write_addr <= '0;
      pixel      <= 1'b0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      oob_err    <= 1'b0;
    end else begin
      we         <= 1'b0;
      clear_done <= 1'b0;
      case (state)
        ARB: begin
          if (clear_start) begin
            state      <= CLEAR;
            clear_busy <= 1'b1;
            clr_cnt    <= '0;
          end else if (transfer) begin
            rr_ptr <= (sel_idx == LAST_REQ) ? '0 : sel_idx + 1'b1;
            if (sel_oob) begin
              oob_err <= 1'b1;
            end else begin
              we         <= 1'b1;
              write_addr <= sel_addr;
              pixel      <= sel_pixel;
            end
          end
        end
        CLEAR: begin
          we         <= 1'b1;
          write_addr <= clr_cnt;
          pixel      <= CLEAR_PIXEL;
          if (clr_cnt == LAST_ADDR) begin
            clr_cnt    <= '0;
            state      <= ARB;
            clear_busy <= 1'b0;
            clear_done <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter: reference grant/clear model pushes expected writes, output side pops.
// Latency: expects each accepted write on the port one cycle after its handshake.
// Backpressure: checks req_ready against the model every cycle, including during clears.
module tb_fb_write_arbiter;
  import fb_pkg::*;

  localparam int AW = 15;
  localparam int NR = 3;

  logic           clk_25 = 1'b0;
  logic           reset_n = 1'b0;
  logic [NR-1:0]  req_valid = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR-1:0]  req_pixel = '0;
  logic [NR-1:0]  req_ready;
  logic           clear_start = 1'b0;
  logic           clear_busy;
  logic           clear_done;
  logic           oob_err;
  logic           we;
  logic [AW-1:0]  write_addr;
  logic           pixel;

  fb_write_arbiter #(
    .ADDR_WIDTH  (AW),
    .N_REQ       (NR),
    .CLEAR_PIXEL (1'b0)
  ) dut (
    .clk_25      (clk_25),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_pixel   (req_pixel),
    .req_ready   (req_ready),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .oob_err     (oob_err),
    .we          (we),
    .write_addr  (write_addr),
    .pixel       (pixel)
  );

  always #5 clk_25 = ~clk_25;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          pix;
  } wr_t;

  wr_t           sb[$];
  int            total = 0;
  int            bad = 0;
  int            m_ptr = 0;
  bit            m_clr = 0;
  int            m_cnt = 0;
  bit            m_oob = 0;
  logic [AW-1:0] m_last = '0;
  int            done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input bit v, input int addr, input bit pix);
    req_valid[i] = v;
    req_addr[i*AW +: AW] = AW'(addr);
    req_pixel[i] = pix;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_we", 32'(we), 32'(0));
    chk("rst_addr", 32'(write_addr), 32'(0));
    chk("rst_pixel", 32'(pixel), 32'(0));
    chk("rst_busy", 32'(clear_busy), 32'(0));
    chk("rst_done", 32'(clear_done), 32'(0));
    chk("rst_oob", 32'(oob_err), 32'(0));
    sb.delete();
    m_ptr = 0; m_clr = 0; m_cnt = 0; m_oob = 0; m_last = '0;
    @(posedge clk_25);
    #1;
    reset_n = 1'b1;
  endtask

  // One clock: predict handshake and write, then check the registered outputs after the edge
  task automatic tick();
    logic [NR-1:0] eg;
    int  g;
    bit  pushed;
    bit  exp_done;
    wr_t w;
    #1;
    eg = '0; g = -1; pushed = 0; exp_done = 0;
    if (!m_clr && !clear_start) begin
      for (int k = 0; k < NR; k++) begin
        int idx;
        idx = (m_ptr + k) % NR;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) eg[g] = 1'b1;
    chk("ready", 32'(req_ready), 32'(eg));
    if (g >= 0) begin
      w.addr = req_addr[g*AW +: AW];
      w.pix  = req_pixel[g];
      m_ptr  = (g + 1) % NR;
`ifdef FB_BOUNDS_CHECK_EN
      if (int'(w.addr) >= FB_DEPTH) m_oob = 1;
      else begin sb.push_back(w); pushed = 1; end
`else
      sb.push_back(w); pushed = 1;
`endif
    end
    if (m_clr) begin
      w.addr = AW'(m_cnt);
      w.pix  = 1'b0;
      sb.push_back(w); pushed = 1;
      if (m_cnt == FB_DEPTH - 1) begin m_clr = 0; exp_done = 1; end
      m_cnt++;
    end else if (clear_start) begin
      m_clr = 1; m_cnt = 0;
    end
    @(posedge clk_25);
    #1;
    chk("we", 32'(we), 32'(pushed));
    if (pushed && sb.size() > 0) begin
      w = sb.pop_front();
      chk("addr", 32'(write_addr), 32'(w.addr));
      chk("pixel", 32'(pixel), 32'(w.pix));
      m_last = w.addr;
    end else begin
      chk("hold_addr", 32'(write_addr), 32'(m_last));
    end
    chk("busy", 32'(clear_busy), 32'(m_clr));
    chk("done", 32'(clear_done), 32'(exp_done));
    chk("oob", 32'(oob_err), 32'(m_oob));
    if (clear_done) done_cnt++;
  endtask

  // Run a clear to completion; optionally re-pulse clear_start at count 5000
  task automatic run_clear(input bit repulse);
    done_cnt = 0;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < FB_DEPTH + 10 && m_clr; i++) begin
      clear_start = (repulse && m_cnt == 5000) ? 1'b1 : 1'b0;
      tick();
    end
    clear_start = 1'b0;
    chk("clear_finished", 32'(m_clr), 32'(0));
    tick();
    chk("done_pulses", 32'(done_cnt), 32'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // All three writers busy: 0,1,2,0,... with addresses 10/20/30
    set_req(0, 1, 10, 1);
    set_req(1, 1, 20, 0);
    set_req(2, 1, 30, 1);
    repeat (7) tick();

    // Reset in the middle of traffic, then first grant goes to writer 0
    do_reset();
    tick();

    // Lone writer 2 at address 159, then pointer wraps to writer 0
    req_valid = '0;
    set_req(2, 1, 159, 1);
    tick();
    req_valid = '0;
    tick();
    set_req(0, 1, 10, 0);
    set_req(1, 1, 20, 1);
    set_req(2, 1, 30, 0);
    tick();
    tick();

    // Full clear with writers 0/1 holding valid
    req_valid = 3'b011;
    run_clear(0);
    tick();

    // Second clear with an ignored restart pulse midway
    run_clear(1);

    // Reset during a clear aborts it with no done pulse
    req_valid = '0;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (50) tick();
    do_reset();
    repeat (3) tick();

    // Out-of-range address from writer 1
    set_req(1, 1, 19200, 1);
    tick();
    req_valid = '0;
    repeat (2) tick();
    set_req(0, 1, 77, 1);
    tick();
    req_valid = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
